etc_tile_acc: RTL and testbench
===============================

# etc_tile_acc

Downstream accumulation stage for the extended tensor core's 4x4 tile unit. It consumes a sequence of 4x4 result tiles from the tile unit and reduces them element-wise across the K dimension with a selectable semiring reduction: add, add, min or max. It then drains the finished 4x4 tile as four row beats over a valid/ready stream to the writeback path. It holds one tile in flight: accumulate, then drain, then idle.

## Interface
- W, 16, element width in bits; all arithmetic is unsigned.
- KW, 8, width of the tile-count field.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse; latches op and num_k. Honoured only in IDLE.
- op  in  2  reduction select: 0 add (MAC), 1 add (L2D partials), 2 unsigned min, 3 unsigned max.
- num_k  in  KW  number of tiles to reduce; 0 makes start a no-op.
- in_valid  in  1  in_tile is valid.
- in_tile  in  [3:0][3:0][W-1:0]  partial tile from the tile unit; element [r][c].
- in_ready  out  1  tile is accepted when in_valid && in_ready.
- out_valid  out  1  out_row is valid.
- out_ready  in  1  consumer accepts the row.
- out_row  out  [3:0][W-1:0]  one row of the accumulated tile; element [c].
- out_row_idx  out  2  row index of out_row, 0..3.
- out_last  out  1  high with row 3.
- busy  out  1  high in ACC or DRAIN.

## Operation
- States: IDLE, ACC, DRAIN. Reset enters IDLE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start && num_k!=0 latches op and num_k, clears the tile counter, and loads every acc element with the identity for the op: 0 for ops 0/1/3, {W{1'b1}} for op 2. Next state is ACC.
- ACC:
  - in_ready=1.
  - On each accepted tile, acc[r][c] <= f(acc[r][c], in_tile[r][c]) for all 16 elements.
  - Add wraps modulo 2^W with no saturation. Min and max are unsigned compares.
  - The counter increments on each accept. When the accept brings the count to num_k, next state is DRAIN with row pointer 0.
- DRAIN:
  - out_valid=1, out_row=acc[row], out_row_idx=row, out_last=(row==3).
  - The row pointer advances on out_valid && out_ready. The handshake on row 3 returns the block to IDLE.
  - out_row and out_row_idx stay stable while out_valid && !out_ready.
- start outside IDLE is ignored, and op/num_k changes outside IDLE have no effect.
- in_valid while in_ready=0 is not accepted. The producer holds the tile.
- Reset (rst_n=0 at a clock edge) in any state: state IDLE, acc cleared to 0, counter 0, row pointer 0. Any partial accumulation is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, out_row=0, out_row_idx=0, out_last=0, busy=0.
- All outputs are registered or derived from registered state only. There is no combinational in-to-out path, including in_valid→in_ready and out_ready→out_valid.
- Timeline:
  - start at edge T: ACC, in_ready=1 and busy=1 from T+1.
  - Sustained throughput in ACC is one tile per cycle.
  - Last tile accepted at edge L: DRAIN from L+1, out_valid=1 with row 0 at L+1.
  - With out_ready held high, rows 0..3 occupy cycles L+1..L+4 and IDLE is entered at L+5.
- Minimum start-to-IDLE time is num_k+5 cycles. No back-to-back start overlap: a start accepted in IDLE becomes effective at the next edge.
- start and the first in_valid in the same cycle: the tile is not accepted (in_ready=0 in IDLE). It is accepted at the next edge if in_valid is held.
- num_k=255 (max) counts correctly with no counter wrap. The counter is KW bits wide and is compared before incrementing.

## Test plan
- Add, num_k=2, op=0: tile1 all elements 3, tile2 element [r][c]=r*4+c. Required rows: row0 {3,4,5,6}, row3 {15,16,17,18}, out_last only on row 3.
- Wrap, op=1, num_k=2: tiles all 16'hFFFF and 16'h0002. Required: every element 16'h0001.
- Min/max, num_k=3, element [0][0] values 9, 4, 7. Required: op=2 gives 4 and op=3 gives 9. An op=2 run with num_k=1 and a tile of all 16'hFFFF gives 16'hFFFF (identity intact).
- Backpressure in DRAIN: out_ready low for 3 cycles on row 1. Required: out_row and out_row_idx=1 held stable, no row skipped, IDLE reached only after the row-3 handshake. A start pulsed during DRAIN is ignored (busy stays 1 and no new ACC).
- Producer gaps and num_k=0: in_valid toggling 1,0,1 with num_k=2. Required: exactly 2 tiles reduced. start with num_k=0 leaves busy=0 and in_ready=0.
- Reset mid-ACC after 1 of 3 tiles. Required: all outputs 0 on the next cycle. A subsequent run with op=0, num_k=1 and a tile of all 5s outputs all 5s, with no residue from the aborted run.

Source files
------------

// File: rtl/etc_tile_acc.sv
// etc_tile_acc: element-wise K-dimension reduction of 4x4 result tiles
// (add / add / unsigned min / unsigned max), drained as four row beats
// over a valid/ready stream. One tile in flight: IDLE -> ACC -> DRAIN.
module etc_tile_acc #(
  parameter int W  = 16,
  parameter int KW = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [KW-1:0]             num_k,
  input  logic                      in_valid,
  input  logic [3:0][3:0][W-1:0]    in_tile,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0][W-1:0]         out_row,
  output logic [1:0]                out_row_idx,
  output logic                      out_last,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] OP_MIN = 2'd2;
  localparam logic [1:0] OP_MAX = 2'd3;

  state_t                   state_q, state_d;
  logic [1:0]               op_q, op_d;
  logic [KW-1:0]            num_k_q, num_k_d;
  logic [KW-1:0]            cnt_q, cnt_d;
  logic [1:0]               row_q, row_d;
  logic [3:0][3:0][W-1:0]   acc_q, acc_d;

  // Per-element reduction result of the current accumulator and incoming tile
  logic [W-1:0]             red [16];

  // Identity element for the op presented with start (all ones for min)
  logic [W-1:0]             ident;
  assign ident = (op == OP_MIN) ? {W{1'b1}} : {W{1'b0}};

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_red
      localparam int R = gi / 4;
      localparam int C = gi % 4;
      // Reduce one element with the latched op; add wraps modulo 2^W
      always_comb begin
        case (op_q)
          OP_MIN:  red[gi] = (acc_q[R][C] < in_tile[R][C]) ? acc_q[R][C] : in_tile[R][C];
          OP_MAX:  red[gi] = (acc_q[R][C] > in_tile[R][C]) ? acc_q[R][C] : in_tile[R][C];
          default: red[gi] = acc_q[R][C] + in_tile[R][C];
        endcase
      end
    end
  endgenerate

  // Next-state logic: start latching, tile accept/count, row drain
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    num_k_d = num_k_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (num_k != '0)) begin
          state_d = ST_ACC;
          op_d    = op;
          num_k_d = num_k;
          cnt_d   = '0;
          row_d   = 2'd0;
          for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
              acc_d[r][c] = ident;
            end
          end
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
              acc_d[r][c] = red[r*4 + c];
            end
          end
          cnt_d = cnt_q + KW'(1);
          // Compare before incrementing so num_k at its maximum never wraps
          if (cnt_q == (num_k_q - KW'(1))) begin
            state_d = ST_DRAIN;
            row_d   = 2'd0;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any partial accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 2'd0;
      num_k_q <= '0;
      cnt_q   <= '0;
      row_q   <= 2'd0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      num_k_q <= num_k_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
    end
  end

  // Outputs depend on registered state only
  assign in_ready    = (state_q == ST_ACC);
  assign out_valid   = (state_q == ST_DRAIN);
  assign busy        = (state_q != ST_IDLE);
  assign out_row     = out_valid ? acc_q[row_q] : '0;
  assign out_row_idx = row_q;
  assign out_last    = out_valid && (row_q == 2'd3);

endmodule

// File: tb/tb_etc_tile_acc.sv
// Bench for etc_tile_acc: directed runs checked every cycle against a
// phase/array model of the reduction, plus literal row expectations.
module tb_etc_tile_acc;
  localparam int W  = 16;
  localparam int KW = 8;

  typedef logic [3:0][3:0][W-1:0] tile_t;
  typedef logic [3:0][W-1:0]      row_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [KW-1:0] num_k = '0;
  logic          in_valid = 1'b0;
  tile_t         in_tile = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  row_t          out_row;
  logic [1:0]    out_row_idx;
  logic          out_last;
  logic          busy;

  etc_tile_acc #(.W(W), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .num_k(num_k),
    .in_valid(in_valid), .in_tile(in_tile), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic tile_t mk_const(input int v);
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = W'(v);
    return t;
  endfunction

  function automatic tile_t mk_ramp();
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = W'(r * 4 + c);
    return t;
  endfunction

  function automatic row_t rowv(input int e0, input int e1, input int e2, input int e3);
    row_t x;
    x[0] = W'(e0); x[1] = W'(e1); x[2] = W'(e2); x[3] = W'(e3);
    return x;
  endfunction

  // Model: phase 0 idle, 1 accumulating, 2 draining; plain-integer tile math
  int m_mode = 0;
  int m_op = 0;
  int m_k = 0;
  int m_cnt = 0;
  int m_row = 0;
  int m_acc [4][4];

  function automatic int reduce(input int o, input int a, input int b);
    if (o == 2) return (a < b) ? a : b;
    if (o == 3) return (a > b) ? a : b;
    return (a + b) % 65536;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_row = 0; m_cnt = 0;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m_acc[r][c] = 0;
    end else if (m_mode == 0) begin
      if (start && num_k != 0) begin
        m_mode = 1; m_op = int'(op); m_k = int'(num_k); m_cnt = 0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            m_acc[r][c] = (op == 2'd2) ? 65535 : 0;
      end
    end else if (m_mode == 1) begin
      if (in_valid) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            m_acc[r][c] = reduce(m_op, m_acc[r][c], int'(in_tile[r][c]));
        m_cnt++;
        if (m_cnt == m_k) begin m_mode = 2; m_row = 0; end
      end
    end else begin
      if (out_ready) begin
        if (m_row == 3) m_mode = 0;
        else m_row++;
      end
    end
  end

  // Rows observed on each drain handshake, indexed by reported row
  row_t       cap [4];
  logic [3:0] cap_last = '0;

  // Per-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(in_ready), 64'(m_mode == 1));
      check("out_valid", 64'(out_valid), 64'(m_mode == 2));
      check("busy", 64'(busy), 64'(m_mode != 0));
      check("out_last", 64'(out_last), 64'(m_mode == 2 && m_row == 3));
      if (m_mode == 2) begin
        check("out_row", 64'(out_row),
              64'(rowv(m_acc[m_row][0], m_acc[m_row][1], m_acc[m_row][2], m_acc[m_row][3])));
        check("out_row_idx", 64'(out_row_idx), 64'(m_row));
      end
      if (out_valid && out_ready) begin
        cap[out_row_idx]      = out_row;
        cap_last[out_row_idx] = out_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [1:0] o, input int k);
    op = o; num_k = KW'(k); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input tile_t t);
    in_tile = t; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && m_mode != 0; i++) tick();
    check("idle_after_drain", 64'(busy), 64'(0));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_row"}, 64'(out_row), 64'(0));
    check({tag, "_out_row_idx"}, 64'(out_row_idx), 64'(0));
    check({tag, "_out_last"}, 64'(out_last), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    tick();
    tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Add: constant 3 plus ramp
    start_run(2'd0, 2);
    send(mk_const(3));
    send(mk_ramp());
    wait_idle();
    check("add_row0", 64'(cap[0]), 64'(rowv(3, 4, 5, 6)));
    check("add_row3", 64'(cap[3]), 64'(rowv(15, 16, 17, 18)));
    check("add_last", 64'(cap_last), 64'(4'b1000));

    // Wrap: FFFF + 0002 = 0001
    start_run(2'd1, 2);
    send(mk_const(16'hFFFF));
    send(mk_const(16'h0002));
    wait_idle();
    check("wrap_row2", 64'(cap[2]), 64'(rowv(1, 1, 1, 1)));

    // Min and max over 9, 4, 7
    start_run(2'd2, 3);
    send(mk_const(9)); send(mk_const(4)); send(mk_const(7));
    wait_idle();
    check("min_elem00", 64'(cap[0][0]), 64'(4));
    start_run(2'd3, 3);
    send(mk_const(9)); send(mk_const(4)); send(mk_const(7));
    wait_idle();
    check("max_elem00", 64'(cap[0][0]), 64'(9));
    start_run(2'd2, 1);
    send(mk_const(16'hFFFF));
    wait_idle();
    check("min_identity", 64'(cap[1]), 64'(rowv(65535, 65535, 65535, 65535)));

    // Backpressure on row 1 with a start pulse during drain
    start_run(2'd0, 1);
    out_ready = 1'b0;
    send(mk_ramp());
    check("bp_row0_idx", 64'(out_row_idx), 64'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    op = 2'd0; num_k = KW'(1); start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) start = 1'b0;
      check("bp_hold_idx", 64'(out_row_idx), 64'(1));
      check("bp_hold_row", 64'(out_row), 64'(rowv(4, 5, 6, 7)));
      check("bp_hold_busy", 64'(busy), 64'(1));
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("bp_row1", 64'(cap[1]), 64'(rowv(4, 5, 6, 7)));
    check("bp_row2", 64'(cap[2]), 64'(rowv(8, 9, 10, 11)));
    tick();
    check("bp_no_new_acc", 64'(in_ready), 64'(0));

    // Producer gap: only valid tiles are reduced
    start_run(2'd0, 2);
    send(mk_const(1));
    in_tile = mk_const(100); in_valid = 1'b0;
    tick();
    send(mk_const(2));
    wait_idle();
    check("gap_row0", 64'(cap[0]), 64'(rowv(3, 3, 3, 3)));

    // num_k = 0 makes start a no-op
    start_run(2'd0, 0);
    check("k0_busy", 64'(busy), 64'(0));
    check("k0_in_ready", 64'(in_ready), 64'(0));

    // Reset mid-accumulation, then a clean run
    start_run(2'd0, 3);
    send(mk_const(7));
    rst_n = 1'b0;
    tick();
    check_zero_outputs("midreset");
    rst_n = 1'b1;
    tick();
    start_run(2'd0, 1);
    send(mk_const(5));
    wait_idle();
    check("post_reset_row3", 64'(cap[3]), 64'(rowv(5, 5, 5, 5)));

    // Maximum tile count without counter wrap
    start_run(2'd0, 255);
    for (int i = 0; i < 255; i++) send(mk_const(1));
    wait_idle();
    check("k255_row0", 64'(cap[0]), 64'(rowv(255, 255, 255, 255)));

    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
